// File: rtl/retire_trace_fifo.sv
// Retire-event tracer: tags retire events with an instruction number and queues them.
// Optional TRACE_FILTER_EN adds filter_mask to suppress pushes of selected event kinds.
module retire_trace_fifo #(
   parameter int DATA_W     = 16,
   parameter int REG_W      = 4,
   parameter int DEPTH      = 8,
   parameter int CNT_W      = 32,
   parameter int WDOG_LIMIT = 100000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              ev_valid,
   input  logic [1:0]        ev_kind,
   input  logic [DATA_W-1:0] ev_pc,
   input  logic [REG_W-1:0]  ev_reg,
   input  logic [DATA_W-1:0] ev_data,
   input  logic [DATA_W-1:0] ev_addr,
   input  logic              ev_memrd,
`ifdef TRACE_FILTER_EN
   input  logic [3:0]        filter_mask,
`endif
   output logic              tr_valid,
   input  logic              tr_ready,
   output logic [1:0]        tr_kind,
   output logic [DATA_W-1:0] tr_pc,
   output logic [REG_W-1:0]  tr_reg,
   output logic [DATA_W-1:0] tr_data,
   output logic [DATA_W-1:0] tr_addr,
   output logic              tr_memrd,
   output logic [CNT_W-1:0]  tr_inum,
   output logic [CNT_W-1:0]  inst_count,
   output logic [CNT_W-1:0]  cycle_count,
   output logic              halted,
   output logic              wdog_timeout,
   output logic              overflow
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {RUN, DRAIN, DONE, TIMEOUT} state_t;

   typedef struct packed {
      logic [1:0]        kind;
      logic [DATA_W-1:0] pc;
      logic [REG_W-1:0]  rg;
      logic [DATA_W-1:0] data;
      logic [DATA_W-1:0] addr;
      logic              memrd;
      logic [CNT_W-1:0]  inum;
   } entry_t;

   state_t            state;
   state_t            stateNxt;
   entry_t            mem [DEPTH];
   entry_t            pushEnt;
   entry_t            headEnt;
   logic [AW:0]       wrPtr;
   logic [AW:0]       rdPtr;
   logic [AW:0]       fill;
   logic [CNT_W-1:0]  instCnt;
   logic [CNT_W-1:0]  cycleCnt;
   logic              ovfl;
   logic              empty;
   logic              full;
   logic              evAcc;
   logic              isHalt;
   logic              filtered;
   logic              pushReq;
   logic              pop;
   logic              doPush;
   logic              drop;
   logic              wdogHit;
   logic              counting;

   assign empty = (wrPtr == rdPtr);
   assign full  = (wrPtr[AW] != rdPtr[AW]) &&
                  (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
   assign fill  = wrPtr - rdPtr;

   assign evAcc  = (state == RUN) && ev_valid;
   assign isHalt = (ev_kind == 2'b11);

`ifdef TRACE_FILTER_EN
   // Halt is never filtered so the drain sequence always sees it.
   assign filtered = filter_mask[ev_kind] && !isHalt;
`else
   assign filtered = 1'b0;
`endif

   assign pushReq  = evAcc && !filtered;
   assign pop      = !empty && tr_ready;
   assign doPush   = pushReq && (!full || pop);
   assign drop     = pushReq && full && !pop;
   assign wdogHit  = (cycleCnt == CNT_W'(WDOG_LIMIT - 1));
   assign counting = (state == RUN) || (state == DRAIN);

   assign pushEnt = '{kind:  ev_kind,
                      pc:    ev_pc,
                      rg:    ev_reg,
                      data:  ev_data,
                      addr:  ev_addr,
                      memrd: ev_memrd,
                      inum:  instCnt};

   always_comb begin
      stateNxt = state;
      unique case (state)
         RUN: begin
            if (evAcc && isHalt)
               stateNxt = DRAIN;
            else if (wdogHit)
               stateNxt = TIMEOUT;
         end
         DRAIN: begin
            if (empty || (pop && fill == (AW+1)'(1)))
               stateNxt = DONE;
         end
         DONE:    stateNxt = DONE;
         TIMEOUT: stateNxt = TIMEOUT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= RUN;
         wrPtr    <= '0;
         rdPtr    <= '0;
         instCnt  <= '0;
         cycleCnt <= '0;
         ovfl     <= 1'b0;
      end else begin
         state <= stateNxt;
         if (doPush)
            wrPtr <= wrPtr + 1'b1;
         if (pop)
            rdPtr <= rdPtr + 1'b1;
         if (evAcc && instCnt != '1)
            instCnt <= instCnt + 1'b1;
         if (counting && cycleCnt != '1)
            cycleCnt <= cycleCnt + 1'b1;
         if (drop)
            ovfl <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && doPush)
         mem[wrPtr[AW-1:0]] <= pushEnt;
   end

   // Gate the head so fields read as zero whenever the queue is empty.
   assign headEnt = empty ? '0 : mem[rdPtr[AW-1:0]];

   assign tr_valid     = !empty;
   assign tr_kind      = headEnt.kind;
   assign tr_pc        = headEnt.pc;
   assign tr_reg       = headEnt.rg;
   assign tr_data      = headEnt.data;
   assign tr_addr      = headEnt.addr;
   assign tr_memrd     = headEnt.memrd;
   assign tr_inum      = headEnt.inum;
   assign inst_count   = instCnt;
   assign cycle_count  = cycleCnt;
   assign halted       = (state == DONE);
   assign wdog_timeout = (state == TIMEOUT);
   assign overflow     = ovfl;

endmodule

// File: tb/tb_retire_trace_fifo.sv
// Scoreboard bench for retire_trace_fifo; a second instance with a short
// watchdog limit shares the stimulus for the timeout scenario.
module tb_retire_trace_fifo;

   localparam int DW = 16;
   localparam int RW = 4;
   localparam int DEPTH = 8;
   localparam int CW = 32;

   typedef struct packed {
      logic [1:0]    kind;
      logic [DW-1:0] pc;
      logic [RW-1:0] rg;
      logic [DW-1:0] data;
      logic [DW-1:0] addr;
      logic          memrd;
      logic [CW-1:0] inum;
   } ent_t;

   logic          clk;
   logic          rst_n;
   logic          ev_valid;
   logic [1:0]    ev_kind;
   logic [DW-1:0] ev_pc;
   logic [RW-1:0] ev_reg;
   logic [DW-1:0] ev_data;
   logic [DW-1:0] ev_addr;
   logic          ev_memrd;
   logic [3:0]    filter_mask;
   logic          tr_ready;

   logic          tr_valid;
   logic [1:0]    tr_kind;
   logic [DW-1:0] tr_pc;
   logic [RW-1:0] tr_reg;
   logic [DW-1:0] tr_data;
   logic [DW-1:0] tr_addr;
   logic          tr_memrd;
   logic [CW-1:0] tr_inum;
   logic [CW-1:0] inst_count;
   logic [CW-1:0] cycle_count;
   logic          halted;
   logic          wdog_timeout;
   logic          overflow;

   logic          wValid;
   logic [1:0]    wKind;
   logic [DW-1:0] wPc;
   logic [RW-1:0] wReg;
   logic [DW-1:0] wData;
   logic [DW-1:0] wAddr;
   logic          wMemrd;
   logic [CW-1:0] wInum;
   logic [CW-1:0] wInst;
   logic [CW-1:0] wCycle;
   logic          wHalted;
   logic          wTimeout;
   logic          wOvfl;

   int   vectors = 0;
   int   errors = 0;
   int   popCount = 0;
   ent_t sbq[$];

   retire_trace_fifo #(
      .DATA_W(DW), .REG_W(RW), .DEPTH(DEPTH), .CNT_W(CW), .WDOG_LIMIT(200)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ev_valid(ev_valid), .ev_kind(ev_kind), .ev_pc(ev_pc),
      .ev_reg(ev_reg), .ev_data(ev_data), .ev_addr(ev_addr),
      .ev_memrd(ev_memrd),
`ifdef TRACE_FILTER_EN
      .filter_mask(filter_mask),
`endif
      .tr_valid(tr_valid), .tr_ready(tr_ready), .tr_kind(tr_kind),
      .tr_pc(tr_pc), .tr_reg(tr_reg), .tr_data(tr_data),
      .tr_addr(tr_addr), .tr_memrd(tr_memrd), .tr_inum(tr_inum),
      .inst_count(inst_count), .cycle_count(cycle_count),
      .halted(halted), .wdog_timeout(wdog_timeout), .overflow(overflow)
   );

   retire_trace_fifo #(
      .DATA_W(DW), .REG_W(RW), .DEPTH(DEPTH), .CNT_W(CW), .WDOG_LIMIT(20)
   ) dutW (
      .clk(clk), .rst_n(rst_n),
      .ev_valid(ev_valid), .ev_kind(ev_kind), .ev_pc(ev_pc),
      .ev_reg(ev_reg), .ev_data(ev_data), .ev_addr(ev_addr),
      .ev_memrd(ev_memrd),
`ifdef TRACE_FILTER_EN
      .filter_mask(filter_mask),
`endif
      .tr_valid(wValid), .tr_ready(tr_ready), .tr_kind(wKind),
      .tr_pc(wPc), .tr_reg(wReg), .tr_data(wData),
      .tr_addr(wAddr), .tr_memrd(wMemrd), .tr_inum(wInum),
      .inst_count(wInst), .cycle_count(wCycle),
      .halted(wHalted), .wdog_timeout(wTimeout), .overflow(wOvfl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Head entries are compared against the scoreboard whenever a pop happens.
   always @(negedge clk) begin
      if (rst_n && tr_valid && tr_ready) begin
         ent_t exp;
         ent_t act;
         act = '{tr_kind, tr_pc, tr_reg, tr_data, tr_addr, tr_memrd, tr_inum};
         vectors++;
         if (sbq.size() == 0) begin
            errors++;
            $display("FAIL sb_extra got inum=%0d want no entry", tr_inum);
         end else begin
            exp = sbq.pop_front();
            popCount++;
            if (act !== exp) begin
               errors++;
               $display("FAIL sb_head got %h want %h", act, exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] k, input logic [DW-1:0] pc,
                        input logic [RW-1:0] rg, input logic [DW-1:0] d,
                        input logic [DW-1:0] a, input logic m,
                        input bit keep, input int inum);
      ev_valid = 1'b1;
      ev_kind  = k;
      ev_pc    = pc;
      ev_reg   = rg;
      ev_data  = d;
      ev_addr  = a;
      ev_memrd = m;
      if (keep)
         sbq.push_back('{k, pc, rg, d, a, m, CW'(inum)});
   endtask

   task automatic idle();
      ev_valid = 1'b0;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      ev_valid = 1'b0;
      tr_ready = 1'b0;
      filter_mask = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      sbq.delete();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tr_ready = 1'b1;
      drive(2'b01, 16'h1234, 4'd5, 16'h5555, 16'h0042, 1'b1, 1'b0, 0);
      repeat (3) tick();
      vectors++;
      if (tr_valid !== 1'b0 || tr_inum !== '0 || tr_pc !== '0) begin
         errors++;
         $display("FAIL rst_head got v=%b pc=%h want 0", tr_valid, tr_pc);
      end
      vectors++;
      if (inst_count !== '0 || cycle_count !== '0) begin
         errors++;
         $display("FAIL rst_cnt got %0d/%0d want 0/0",
                  inst_count, cycle_count);
      end
      vectors++;
      if ({halted, wdog_timeout, overflow} !== 3'b000) begin
         errors++;
         $display("FAIL rst_status got %b want 000",
                  {halted, wdog_timeout, overflow});
      end
      doReset();
   endtask

   task automatic test_basic();
      logic [CW-1:0] expInum [3];
      expInum[0] = 0;
      expInum[1] = 1;
      expInum[2] = 2;
      doReset();
      tr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         unique case (i)
            0: drive(2'b01, 16'h0002, 4'd3, 16'h00AA, 16'h0, 1'b0, 1'b1, 0);
            1: drive(2'b10, 16'h0004, 4'd0, 16'h0055, 16'h0010, 1'b0, 1'b1, 1);
            default: drive(2'b00, 16'h0006, 4'd0, 16'h0, 16'h0, 1'b0, 1'b1, 2);
         endcase
         tick();
         vectors++;
         if (tr_valid !== 1'b1 || tr_inum !== expInum[i]) begin
            errors++;
            $display("FAIL basic_latency got v=%b inum=%0d want v=1 inum=%0d",
                     tr_valid, tr_inum, expInum[i]);
         end
      end
      idle();
      repeat (2) tick();
      vectors++;
      if (inst_count !== 32'd3 || tr_valid !== 1'b0) begin
         errors++;
         $display("FAIL basic_count got %0d v=%b want 3 v=0",
                  inst_count, tr_valid);
      end
      vectors++;
      if (sbq.size() != 0) begin
         errors++;
         $display("FAIL basic_drain got %0d left want 0", sbq.size());
      end
   endtask

   task automatic test_overflow();
      int start;
      doReset();
      for (int i = 0; i < DEPTH + 2; i++) begin
         drive(2'b01, DW'(2 * i), RW'(i), DW'(16'h100 + i), 16'h0,
               1'(i & 1), i < DEPTH, i);
         tick();
      end
      idle();
      tick();
      vectors++;
      if (overflow !== 1'b1 || inst_count !== CW'(DEPTH + 2)) begin
         errors++;
         $display("FAIL ovf_flag got ovf=%b cnt=%0d want 1/%0d",
                  overflow, inst_count, DEPTH + 2);
      end
      start = popCount;
      tr_ready = 1'b1;
      repeat (DEPTH + 3) tick();
      vectors++;
      if (popCount - start != DEPTH || tr_valid !== 1'b0) begin
         errors++;
         $display("FAIL ovf_drain got %0d pops want %0d",
                  popCount - start, DEPTH);
      end
   endtask

   task automatic test_back_to_back();
      int start;
      doReset();
      for (int i = 0; i < DEPTH; i++) begin
         drive(2'b01, DW'(i), RW'(i), DW'(i * 3), 16'h0, 1'b0, 1'b1, i);
         tick();
      end
      tr_ready = 1'b1;
      for (int i = DEPTH; i < DEPTH + 5; i++) begin
         drive(2'b10, DW'(i), 4'd0, DW'(i * 7), DW'(i * 2), 1'b0, 1'b1, i);
         tick();
      end
      idle();
      tr_ready = 1'b0;
      tick();
      vectors++;
      if (overflow !== 1'b0 || tr_valid !== 1'b1) begin
         errors++;
         $display("FAIL b2b_ovf got ovf=%b v=%b want 0/1", overflow, tr_valid);
      end
      vectors++;
      if (inst_count !== CW'(DEPTH + 5)) begin
         errors++;
         $display("FAIL b2b_cnt got %0d want %0d", inst_count, DEPTH + 5);
      end
      start = popCount;
      tr_ready = 1'b1;
      repeat (DEPTH + 2) tick();
      vectors++;
      if (popCount - start != DEPTH) begin
         errors++;
         $display("FAIL b2b_level got %0d want %0d", popCount - start, DEPTH);
      end
   endtask

   task automatic test_halt();
      doReset();
      drive(2'b01, 16'h0010, 4'd1, 16'h0011, 16'h0, 1'b0, 1'b1, 0);
      tick();
      drive(2'b01, 16'h0012, 4'd2, 16'h0022, 16'h0030, 1'b1, 1'b1, 1);
      tick();
      drive(2'b11, 16'h0020, 4'd0, 16'h0, 16'h0, 1'b0, 1'b1, 2);
      tick();
      drive(2'b01, 16'h0024, 4'd7, 16'hBEEF, 16'h0, 1'b0, 1'b0, 0);
      repeat (4) tick();
      vectors++;
      if (halted !== 1'b0 || inst_count !== 32'd3) begin
         errors++;
         $display("FAIL halt_wait got h=%b cnt=%0d want 0/3",
                  halted, inst_count);
      end
      tr_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (halted !== (i == 2)) begin
            errors++;
            $display("FAIL halt_rise pop%0d got %b want %b", i, halted, i == 2);
         end
      end
      repeat (3) tick();
      vectors++;
      if (inst_count !== 32'd3 || cycle_count !== 32'd10 || tr_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_frozen got cnt=%0d cyc=%0d want 3/10",
                  inst_count, cycle_count);
      end
      idle();
   endtask

   task automatic test_halt_dropped();
      int start;
      doReset();
      for (int i = 0; i < DEPTH; i++) begin
         drive(2'b00, DW'(4 * i), 4'd0, 16'h0, 16'h0, 1'b0, 1'b1, i);
         tick();
      end
      drive(2'b11, 16'h0040, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
      tick();
      idle();
      vectors++;
      if (overflow !== 1'b1 || inst_count !== CW'(DEPTH + 1) || halted !== 1'b0) begin
         errors++;
         $display("FAIL hdrop_flag got ovf=%b cnt=%0d h=%b want 1/%0d/0",
                  overflow, inst_count, halted, DEPTH + 1);
      end
      start = popCount;
      tr_ready = 1'b1;
      repeat (DEPTH) tick();
      vectors++;
      if (halted !== 1'b1 || popCount - start != DEPTH) begin
         errors++;
         $display("FAIL hdrop_done got h=%b pops=%0d want 1/%0d",
                  halted, popCount - start, DEPTH);
      end
   endtask

   task automatic test_watchdog();
      doReset();
      tr_ready = 1'b1;
      repeat (19) tick();
      vectors++;
      if (wTimeout !== 1'b0 || wCycle !== 32'd19) begin
         errors++;
         $display("FAIL wdog_early got to=%b cyc=%0d want 0/19",
                  wTimeout, wCycle);
      end
      tick();
      vectors++;
      if (wTimeout !== 1'b1 || wCycle !== 32'd20) begin
         errors++;
         $display("FAIL wdog_hit got to=%b cyc=%0d want 1/20",
                  wTimeout, wCycle);
      end
      tick();
      drive(2'b11, 16'h0020, 4'd0, 16'h0, 16'h0, 1'b0, 1'b1, 0);
      tick();
      idle();
      repeat (2) tick();
      vectors++;
      if (wHalted !== 1'b0 || wInst !== '0 || wValid !== 1'b0 ||
          wCycle !== 32'd20 || wTimeout !== 1'b1) begin
         errors++;
         $display("FAIL wdog_late_halt got h=%b n=%0d v=%b cyc=%0d want 0/0/0/20",
                  wHalted, wInst, wValid, wCycle);
      end
   endtask

`ifdef TRACE_FILTER_EN
   task automatic test_filter();
      int start;
      doReset();
      filter_mask = 4'b0001;
      drive(2'b00, 16'h0002, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 0);
      tick();
      drive(2'b01, 16'h0004, 4'd9, 16'h0099, 16'h0, 1'b0, 1'b1, 1);
      tick();
      drive(2'b00, 16'h0006, 4'd0, 16'h0, 16'h0, 1'b0, 1'b0, 2);
      tick();
      drive(2'b11, 16'h0008, 4'd0, 16'h0, 16'h0, 1'b0, 1'b1, 3);
      tick();
      idle();
      vectors++;
      if (inst_count !== 32'd4) begin
         errors++;
         $display("FAIL filt_cnt got %0d want 4", inst_count);
      end
      start = popCount;
      tr_ready = 1'b1;
      repeat (4) tick();
      vectors++;
      if (popCount - start != 2 || halted !== 1'b1) begin
         errors++;
         $display("FAIL filt_pops got %0d h=%b want 2/1",
                  popCount - start, halted);
      end
   endtask
`endif

   initial begin
      rst_n = 1'b0;
      ev_valid = 1'b0;
      ev_kind = 2'b00;
      ev_pc = '0;
      ev_reg = '0;
      ev_data = '0;
      ev_addr = '0;
      ev_memrd = 1'b0;
      filter_mask = 4'b0000;
      tr_ready = 1'b0;
      test_reset();
      test_basic();
      test_overflow();
      test_back_to_back();
      test_halt();
      test_halt_dropped();
      test_watchdog();
`ifdef TRACE_FILTER_EN
      test_filter();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
